b06_responder: RTL and testbench
================================

B06_RESPONDER -- requirements
Module: b06_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bit width of the reference, data and event counter.
REQ-002 SHALL have parameter LIMIT, default 4'd9: counter value that asserts cont_eql.
REQ-003 SHALL have parameter TMO, default 15: timeout in cycles, COMPARE state, without ackout.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset sampled on clock.
REQ-006 SHALL have port cc_mux, input, [2:1]: compare-source select from the initiator FSM.
REQ-007 SHALL have port uscite, input, [2:1]: initiator output code.
REQ-008 SHALL have port enable_count, input, 1 bit: counter increment enable.
REQ-009 SHALL have port ackout, input, 1 bit: initiator acknowledge.
REQ-010 SHALL have port data_in, input, [WIDTH-1:0]: operand to load or compare.
REQ-011 SHALL have port data_valid, input, 1 bit: load strobe for data_in.
REQ-012 SHALL have port eql, output, 1 bit: registered equality result to the initiator.
REQ-013 SHALL have port cont_eql, output, 1 bit: registered counter-at-LIMIT flag.
REQ-014 SHALL have port busy, output, 1 bit: high in LOAD and COMPARE.
REQ-015 SHALL have port timeout, output, 1 bit: sticky error flag.
REQ-016 SHALL have port last_code, output, [2:1]: last nonzero uscite code captured.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, COMPARE, ACK and ERR.
REQ-018 IDLE SHALL go to LOAD on data_valid=1; LOAD SHALL write data_in into ref and go to COMPARE after 1 cycle.
REQ-019 COMPARE SHALL go to ACK on ackout=1, else SHALL go to ERR when tmo_cnt reaches TMO.
REQ-020 ACK SHALL clear the counter and go to IDLE after 1 cycle; ERR SHALL set timeout and hold until data_valid=1 (go to LOAD, clear timeout) or reset.
REQ-021 In COMPARE, ackout and timeout expiry in the same cycle SHALL give ACK, since ackout has priority.
REQ-022 data_valid SHALL be ignored in LOAD, COMPARE and ACK.
REQ-023 eql SHALL be registered, with 1-cycle latency from inputs; selected by cc_mux: 01 gives data_in==ref, 10 gives cnt==ref, 11 gives cnt==data_in, 00 gives 0.
REQ-024 eql SHALL be forced to 0 in every state except COMPARE.
REQ-025 The counter cnt SHALL increment by 1 per cycle while enable_count=1 and SHALL hold otherwise.
REQ-026 cnt SHALL wrap from 2^WIDTH-1 to 0 with modulo-2^WIDTH arithmetic and no carry out.
REQ-027 When the ACK clear and enable_count=1 occur in the same cycle, the clear SHALL win.
REQ-028 cont_eql SHALL be registered as (cnt==LIMIT), giving 1-cycle latency after cnt reaches LIMIT.
REQ-029 tmo_cnt SHALL reset to 0 on entry to COMPARE and SHALL increment each COMPARE cycle, saturating at TMO.
REQ-030 last_code SHALL update to uscite on any cycle where uscite!=00, and SHALL hold otherwise.

Reset
REQ-031 While reset=0 at a rising clock edge, state SHALL go to IDLE and cnt, ref and tmo_cnt SHALL go to 0.
REQ-032 While reset=0 at a rising clock edge, eql, cont_eql, busy, timeout and last_code SHALL go to 0.
REQ-033 Reset asserted mid-COMPARE or in ERR SHALL abort to IDLE on that edge with no ACK cycle.
REQ-034 Outputs SHALL not change asynchronously on reset.

Verification
REQ-035 Load: reset, data_valid=1 with data_in=5 -> busy=1 next cycle; ref=5; COMPARE after 2 cycles.
REQ-036 Compare: cc_mux=01, data_in=5 in COMPARE -> eql=1 one cycle later; cc_mux=00 -> eql=0 one cycle later.
REQ-037 Counter: enable_count=1 for 9 cycles from 0 -> cont_eql=1 on cycle 10; 16 total increments -> cnt=0 (wrap).
REQ-038 Timeout: ackout held 0 for TMO=15 cycles in COMPARE -> ERR and timeout=1; data_valid then -> timeout=0 and LOAD.
REQ-039 Simultaneous: ackout=1 on the timeout-expiry cycle -> ACK, timeout stays 0; enable_count=1 during ACK -> cnt=0.
REQ-040 Reset mid-op: reset=0 in COMPARE with cnt=7, last_code=10 -> next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/b06_responder.sv
// Responder side of the b06 handshake: loads a reference, compares it against data or an
// event counter on the initiator's request, and flags a sticky timeout if no acknowledge arrives.
module b06_responder #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] LIMIT = 4'd9,
    parameter int               TMO   = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:1]       cc_mux,
    input  logic [2:1]       uscite,
    input  logic             enable_count,
    input  logic             ackout,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             eql,
    output logic             cont_eql,
    output logic             busy,
    output logic             timeout,
    output logic [2:1]       last_code
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        COMPARE = 3'd2,
        ACK     = 3'd3,
        ERR     = 3'd4
    } state_t;

    localparam int            TW       = (TMO < 2) ? 1 : $clog2(TMO + 1);
    localparam logic [TW-1:0] TMO_FULL = TW'(TMO);
    // COMPARE is left on the edge where the count would reach TMO, i.e. after TMO cycles.
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

    state_t           state_r;
    logic [WIDTH-1:0] ref_r;
    logic [WIDTH-1:0] cnt_r;
    logic [TW-1:0]    tmo_cnt_r;
    logic             eql_sel_s;

    // Compare-source multiplexer feeding the registered eql flag.
    always_comb begin
        eql_sel_s = 1'b0;
        case (cc_mux)
            2'b01:   eql_sel_s = (data_in == ref_r);
            2'b10:   eql_sel_s = (cnt_r == ref_r);
            2'b11:   eql_sel_s = (cnt_r == data_in);
            default: eql_sel_s = 1'b0;
        endcase
    end

    // Event counter, its LIMIT flag, the compare result and the last initiator code.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_r     <= '0;
            cont_eql  <= 1'b0;
            eql       <= 1'b0;
            last_code <= 2'b00;
        end else begin
            if (state_r == ACK) begin
                cnt_r <= '0;
            end else if (enable_count) begin
                cnt_r <= cnt_r + WIDTH'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            cont_eql <= (cnt_r == LIMIT);
            eql      <= (state_r == COMPARE) ? eql_sel_s : 1'b0;
            if (uscite != 2'b00) begin
                last_code <= uscite;
            end else begin
                last_code <= last_code;
            end
        end
    end

    // Handshake FSM with registered busy/timeout and the COMPARE watchdog.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r   <= IDLE;
            ref_r     <= '0;
            tmo_cnt_r <= '0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (data_valid) begin
                        state_r <= LOAD;
                        busy    <= 1'b1;
                    end
                end
                LOAD: begin
                    ref_r     <= data_in;
                    tmo_cnt_r <= '0;
                    state_r   <= COMPARE;
                    busy      <= 1'b1;
                end
                COMPARE: begin
                    if (tmo_cnt_r != TMO_FULL) begin
                        tmo_cnt_r <= tmo_cnt_r + TW'(1);
                    end
                    if (ackout) begin
                        state_r <= ACK;
                        busy    <= 1'b0;
                    end else if (tmo_cnt_r == TMO_LAST) begin
                        state_r <= ERR;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                    end
                end
                ACK: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
                ERR: begin
                    if (data_valid) begin
                        state_r <= LOAD;
                        busy    <= 1'b1;
                        timeout <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    timeout <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_b06_responder.sv
// Directed bench for b06_responder: load, compare, counter wrap, timeout, ack priority, reset abort.
module tb_b06_responder;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:1] cc_mux;
    logic [2:1] uscite;
    logic       enable_count;
    logic       ackout;
    logic [3:0] data_in;
    logic       data_valid;
    logic       eql;
    logic       cont_eql;
    logic       busy;
    logic       timeout;
    logic [2:1] last_code;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    b06_responder #(.WIDTH(4), .LIMIT(4'd9), .TMO(15)) dut (
        .clock        (clock),
        .reset        (reset),
        .cc_mux       (cc_mux),
        .uscite       (uscite),
        .enable_count (enable_count),
        .ackout       (ackout),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .eql          (eql),
        .cont_eql     (cont_eql),
        .busy         (busy),
        .timeout      (timeout),
        .last_code    (last_code)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; cc_mux = 2'b00; uscite = 2'b00; enable_count = 1'b0;
        ackout = 1'b0; data_in = 4'd0; data_valid = 1'b0;
        tick(2);
        chk("rst_eql", {7'd0, eql}, 8'd0);
        chk("rst_cont_eql", {7'd0, cont_eql}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_timeout", {7'd0, timeout}, 8'd0);
        chk("rst_last_code", {6'd0, last_code}, 8'd0);
        reset = 1'b1;

        // Load 5, then compare in COMPARE.
        data_in = 4'd5; data_valid = 1'b1; tick(1);
        chk("load_busy", {7'd0, busy}, 8'd1);
        data_valid = 1'b0; tick(1);
        chk("cmp_busy", {7'd0, busy}, 8'd1);
        chk("ref_loaded", {4'd0, dut.ref_r}, 8'd5);
        cc_mux = 2'b01; tick(1);
        chk("eql_data_ref", {7'd0, eql}, 8'd1);
        cc_mux = 2'b00; tick(1);
        chk("eql_sel00", {7'd0, eql}, 8'd0);
        cc_mux = 2'b01; data_in = 4'd6; tick(1);
        chk("eql_data_ne", {7'd0, eql}, 8'd0);
        cc_mux = 2'b11; data_in = 4'd0; tick(1);
        chk("eql_cnt_data", {7'd0, eql}, 8'd1);
        cc_mux = 2'b10; tick(1);
        chk("eql_cnt_ref", {7'd0, eql}, 8'd0);
        cc_mux = 2'b00; ackout = 1'b1; tick(1);
        chk("ack_busy", {7'd0, busy}, 8'd0);
        ackout = 1'b0; tick(1);
        chk("idle_busy", {7'd0, busy}, 8'd0);

        // eql stays 0 outside COMPARE even when the selected operands match.
        cc_mux = 2'b11; data_in = 4'd0; tick(1);
        chk("eql_idle_forced", {7'd0, eql}, 8'd0);
        cc_mux = 2'b00;

        // Counter: LIMIT flag one cycle after reaching 9, wrap after 16.
        enable_count = 1'b1; tick(9);
        chk("cnt_at_9", {4'd0, dut.cnt_r}, 8'd9);
        chk("cont_eql_lat", {7'd0, cont_eql}, 8'd0);
        tick(1);
        chk("cont_eql_set", {7'd0, cont_eql}, 8'd1);
        tick(6);
        chk("cnt_wrap", {4'd0, dut.cnt_r}, 8'd0);
        chk("cont_eql_clr", {7'd0, cont_eql}, 8'd0);
        enable_count = 1'b0; tick(2);
        chk("cnt_hold", {4'd0, dut.cnt_r}, 8'd0);

        // last_code captures nonzero codes only.
        uscite = 2'b10; tick(1);
        chk("code_10", {6'd0, last_code}, 8'd2);
        uscite = 2'b00; tick(1);
        chk("code_hold", {6'd0, last_code}, 8'd2);
        uscite = 2'b01; tick(1);
        chk("code_01", {6'd0, last_code}, 8'd1);
        uscite = 2'b00;

        // Timeout after 15 COMPARE cycles without ackout.
        data_in = 4'd3; data_valid = 1'b1; tick(1);
        data_valid = 1'b0; tick(1);
        tick(14);
        chk("tmo_pre_busy", {7'd0, busy}, 8'd1);
        chk("tmo_pre_flag", {7'd0, timeout}, 8'd0);
        tick(1);
        chk("tmo_busy", {7'd0, busy}, 8'd0);
        chk("tmo_flag", {7'd0, timeout}, 8'd1);
        tick(3);
        chk("tmo_sticky", {7'd0, timeout}, 8'd1);
        data_valid = 1'b1; tick(1);
        chk("err_reload_flag", {7'd0, timeout}, 8'd0);
        chk("err_reload_busy", {7'd0, busy}, 8'd1);
        data_valid = 1'b0; tick(1);

        // Ackout on the expiry cycle wins; ACK clear beats enable_count.
        tick(14);
        chk("sim_pre_busy", {7'd0, busy}, 8'd1);
        ackout = 1'b1; enable_count = 1'b1; tick(1);
        chk("sim_ack_flag", {7'd0, timeout}, 8'd0);
        chk("sim_ack_busy", {7'd0, busy}, 8'd0);
        chk("sim_cnt_inc", {4'd0, dut.cnt_r}, 8'd1);
        ackout = 1'b0; tick(1);
        chk("ack_clear_wins", {4'd0, dut.cnt_r}, 8'd0);
        chk("ack_flag_after", {7'd0, timeout}, 8'd0);
        enable_count = 1'b0;

        // Reset in COMPARE with cnt=7 and last_code=10.
        enable_count = 1'b1; tick(7);
        enable_count = 1'b0;
        uscite = 2'b10; tick(1);
        uscite = 2'b00;
        data_in = 4'd4; data_valid = 1'b1; tick(1);
        data_valid = 1'b0; tick(1);
        cc_mux = 2'b01; tick(1);
        chk("mid_eql", {7'd0, eql}, 8'd1);
        chk("mid_cnt", {4'd0, dut.cnt_r}, 8'd7);
        chk("mid_code", {6'd0, last_code}, 8'd2);
        reset = 1'b0; tick(1);
        chk("abort_eql", {7'd0, eql}, 8'd0);
        chk("abort_cont_eql", {7'd0, cont_eql}, 8'd0);
        chk("abort_busy", {7'd0, busy}, 8'd0);
        chk("abort_timeout", {7'd0, timeout}, 8'd0);
        chk("abort_code", {6'd0, last_code}, 8'd0);
        chk("abort_cnt", {4'd0, dut.cnt_r}, 8'd0);
        reset = 1'b1; tick(1);
        chk("abort_no_ack", {7'd0, busy}, 8'd0);
        chk("abort_eql_idle", {7'd0, eql}, 8'd0);
        data_valid = 1'b1; tick(1);
        chk("abort_idle_load", {7'd0, busy}, 8'd1);
        data_valid = 1'b0; cc_mux = 2'b00; tick(1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
